pipeline_trace_buffer: RTL and testbench

- Synthesizable capture buffer that records the pipelined processor's `instruction`/`result` stream in hardware, tagged with cycle stamps.
- Replaces cycle-by-cycle console monitoring with a bounded, readable trace.
- Parametrised in data width, depth, capture mode, full policy and stall watchdog.
- Sits beside the processor core: taps its `instruction` and `result` outputs and drains through a simple pop interface to a bench or debug port.

---
 rtl/pipeline_trace_buffer_if.sv | 42 ++++
 rtl/pipeline_trace_buffer.sv | 177 +++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_trace_buffer_if.sv
// Purpose: bundles the trace buffer's tap, control and pop-side signals.
// Latency: wiring only, no registers.
// Backpressure: none here; pops are requested with rd_en and answered one cycle later.
interface pipeline_trace_buffer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0]  instruction;
    logic [DATA_WIDTH-1:0]  result;
    logic                   arm;
    logic                   stop;
    logic                   clear;
    logic                   rd_en;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_instruction;
    logic [DATA_WIDTH-1:0]  rd_result;
    logic [CYCLE_WIDTH-1:0] rd_cycle;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   capturing;
    logic                   overflow;
    logic                   timeout;
    logic [CYCLE_WIDTH-1:0] cycle_count;

    // The trace buffer itself
    modport slave (
        input  instruction, result, arm, stop, clear, rd_en,
        output rd_valid, rd_instruction, rd_result, rd_cycle, count, empty, full,
               capturing, overflow, timeout, cycle_count
    );

    // The core tap / debug reader driving it
    modport master (
        output instruction, result, arm, stop, clear, rd_en,
        input  rd_valid, rd_instruction, rd_result, rd_cycle, count, empty, full,
               capturing, overflow, timeout, cycle_count
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Purpose: records the core's instruction/result stream with cycle stamps into a ring buffer.
// Latency: capture visible in count 1 cycle after the sampling edge; pop data 1 cycle after rd_en.
// Backpressure: when full either capture stops (STOP_ON_FULL=1) or the oldest entry is overwritten.
module pipeline_trace_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int CYCLE_WIDTH    = 16,
    parameter int CAPTURE_MODE   = 0,
    parameter int STOP_ON_FULL   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    typedef struct packed {
        logic [CYCLE_WIDTH-1:0] cyc;
        logic [DATA_WIDTH-1:0]  instr;
        logic [DATA_WIDTH-1:0]  res;
    } entry_t;

    state_t                 state;
    state_t                 state_nxt;
    entry_t                 mem [DEPTH];
    entry_t                 rd_ent;
    logic                   rd_vld;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   full_q;
    logic                   empty_q;
    logic [CYCLE_WIDTH-1:0] cyc;
    logic [DATA_WIDTH-1:0]  last_instr;
    logic                   last_vld;
    logic [31:0]            wd_cnt;
    logic                   ovf;
    logic                   tmo;

    logic is_full;
    logic arm_go;
    logic cap_evt;
    logic pop;
    logic push;
    logic ovr;
    logic full_stop;
    logic wd_fire;

    // Per-cycle capture, pop, overwrite and stop decisions plus the next occupancy
    always_comb begin
        is_full   = (cnt == CW'(DEPTH));
        arm_go    = bus.arm && (state != CAPTURE);
        cap_evt   = (state == CAPTURE) &&
                    ((CAPTURE_MODE != 0) || !last_vld || (bus.instruction != last_instr));
        pop       = bus.rd_en && (cnt != '0) && !bus.clear;
        // A capture at full without a pop is only taken when overwriting is allowed
        push      = cap_evt && !bus.clear && (!is_full || pop || (STOP_ON_FULL == 0));
        ovr       = push && is_full && !pop;
        // Stop when this capture fills the buffer, or when it is refused because already full
        full_stop = (STOP_ON_FULL != 0) && cap_evt && !bus.clear && !pop &&
                    (cnt >= CW'(DEPTH - 1));
        wd_fire   = (TIMEOUT_CYCLES != 0) && (state == CAPTURE) && !push &&
                    (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
        cnt_nxt   = cnt;
        if (bus.clear) begin
            cnt_nxt = '0;
        end else if (push && !pop && !is_full) begin
            cnt_nxt = cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arm wins over stop outside CAPTURE and is ignored inside it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.arm) state_nxt = CAPTURE;
            CAPTURE:    if (bus.stop || full_stop || wd_fire) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Pointers, occupancy flags and the free-running stamp counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            cyc     <= '0;
        end else begin
            cyc     <= cyc + 1'b1;
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == CW'(DEPTH));
            empty_q <= (cnt_nxt == '0);
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop || ovr) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Change-detect reference, watchdog and sticky status; arm restarts all of them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_instr <= '0;
            last_vld   <= 1'b0;
            wd_cnt     <= '0;
            ovf        <= 1'b0;
            tmo        <= 1'b0;
        end else begin
            if (arm_go) begin
                last_vld <= 1'b0;
                wd_cnt   <= '0;
                ovf      <= 1'b0;
                tmo      <= 1'b0;
            end else begin
                if (push) begin
                    last_instr <= bus.instruction;
                    last_vld   <= 1'b1;
                    wd_cnt     <= '0;
                end else if (state == CAPTURE) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (ovr) ovf <= 1'b1;
                if (wd_fire) tmo <= 1'b1;
            end
        end
    end

    // Entry storage, written only on an accepted capture
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{cyc: cyc, instr: bus.instruction, res: bus.result};
    end

    // Pop data register; read-before-write keeps FIFO order on a full push+pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_ent <= '0;
        end else begin
            rd_vld <= pop;
            if (pop) rd_ent <= mem[rd_ptr];
        end
    end

    assign bus.rd_valid       = rd_vld;
    assign bus.rd_instruction = rd_ent.instr;
    assign bus.rd_result      = rd_ent.res;
    assign bus.rd_cycle       = rd_ent.cyc;
    assign bus.count          = cnt;
    assign bus.empty          = empty_q;
    assign bus.full           = full_q;
    assign bus.capturing      = (state == CAPTURE);
    assign bus.overflow       = ovf;
    assign bus.timeout        = tmo;
    assign bus.cycle_count    = cyc;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Purpose: directed checks of the trace buffer across capture modes, full policies and watchdog.
// Latency: inputs driven 1ns after each rising edge, outputs sampled at the same point.
// Backpressure: pops driven directly through rd_en; each step is a fixed number of cycles.
module tb_pipeline_trace_buffer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    int   c0;
    int   c1;

    always #5 clk = ~clk;

    pipeline_trace_buffer_if #(.DATA_WIDTH(32), .DEPTH(16), .CYCLE_WIDTH(16)) b0 ();
    pipeline_trace_buffer_if #(.DATA_WIDTH(32), .DEPTH(4),  .CYCLE_WIDTH(16)) b1 ();
    pipeline_trace_buffer_if #(.DATA_WIDTH(32), .DEPTH(4),  .CYCLE_WIDTH(16)) b2 ();
    pipeline_trace_buffer_if #(.DATA_WIDTH(32), .DEPTH(16), .CYCLE_WIDTH(16)) b3 ();

    pipeline_trace_buffer u0 (.clk(clk), .reset(reset), .bus(b0));

    pipeline_trace_buffer #(
        .DEPTH(4), .CAPTURE_MODE(1), .STOP_ON_FULL(1), .TIMEOUT_CYCLES(0)
    ) u1 (.clk(clk), .reset(reset), .bus(b1));

    pipeline_trace_buffer #(
        .DEPTH(4), .CAPTURE_MODE(1), .STOP_ON_FULL(0), .TIMEOUT_CYCLES(0)
    ) u2 (.clk(clk), .reset(reset), .bus(b2));

    pipeline_trace_buffer #(
        .DEPTH(16), .CAPTURE_MODE(0), .STOP_ON_FULL(1), .TIMEOUT_CYCLES(8)
    ) u3 (.clk(clk), .reset(reset), .bus(b3));

    // One clock edge; ncyc mirrors the value the cycle counter will hold afterwards
    task automatic tick();
        @(posedge clk);
        if (!reset) ncyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        b0.instruction = '0; b0.result = '0; b0.arm = 0; b0.stop = 0; b0.clear = 0; b0.rd_en = 0;
        b1.instruction = '0; b1.result = '0; b1.arm = 0; b1.stop = 0; b1.clear = 0; b1.rd_en = 0;
        b2.instruction = '0; b2.result = '0; b2.arm = 0; b2.stop = 0; b2.clear = 0; b2.rd_en = 0;
        b3.instruction = '0; b3.result = '0; b3.arm = 0; b3.stop = 0; b3.clear = 0; b3.rd_en = 0;
        tick();
        tick();

        // Reset state
        check("rst_empty",     b0.empty,       64'd1);
        check("rst_full",      b0.full,        64'd0);
        check("rst_count",     b0.count,       64'd0);
        check("rst_capturing", b0.capturing,   64'd0);
        check("rst_rd_valid",  b0.rd_valid,    64'd0);
        check("rst_overflow",  b0.overflow,    64'd0);
        check("rst_timeout",   b0.timeout,     64'd0);
        check("rst_cycle",     b0.cycle_count, 64'd0);
        reset = 1'b0;

        // Mode 0: three cycles of one instruction then a new one give two entries
        b0.arm = 1; b0.instruction = 32'h0000_0013; b0.result = 32'h11;
        tick();
        b0.arm = 0;
        check("t1_capturing", b0.capturing, 64'd1);
        check("t1_cycle_count", b0.cycle_count, 64'(ncyc));
        c0 = ncyc;
        tick(); tick(); tick();
        b0.instruction = 32'h00A0_0093; b0.result = 32'h22;
        tick();
        check("t1_count", b0.count, 64'd2);
        b0.stop = 1;
        tick();
        b0.stop = 0;
        check("t1_stopped", b0.capturing, 64'd0);
        b0.rd_en = 1;
        tick();
        check("t1_pop0_valid", b0.rd_valid,       64'd1);
        check("t1_pop0_instr", b0.rd_instruction, 64'h13);
        check("t1_pop0_res",   b0.rd_result,      64'h11);
        check("t1_pop0_cycle", b0.rd_cycle,       64'(c0));
        tick();
        check("t1_pop1_instr", b0.rd_instruction, 64'h00A0_0093);
        check("t1_pop1_res",   b0.rd_result,      64'h22);
        check("t1_pop1_cycle", b0.rd_cycle,       64'(c0 + 3));
        b0.rd_en = 0;
        tick();
        check("t1_valid_drop", b0.rd_valid, 64'd0);
        check("t1_empty",      b0.empty,    64'd1);
        b0.rd_en = 1;
        tick();
        check("t1_empty_read", b0.rd_valid, 64'd0);
        b0.rd_en = 0;

        // Mode 1, stop on full: six cycles keep only the first four
        b1.arm = 1;
        tick();
        b1.arm = 0;
        c1 = ncyc;
        for (int i = 0; i < 6; i++) begin
            b1.instruction = 32'h100 + i; b1.result = 32'h200 + i;
            tick();
        end
        check("t2_count",     b1.count,     64'd4);
        check("t2_full",      b1.full,      64'd1);
        check("t2_capturing", b1.capturing, 64'd0);
        b1.rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_pop_instr", b1.rd_instruction, 64'(32'h100 + i));
            check("t2_pop_res",   b1.rd_result,      64'(32'h200 + i));
            check("t2_pop_cycle", b1.rd_cycle,       64'(c1 + i));
        end
        b1.rd_en = 0;
        check("t2_empty", b1.empty, 64'd1);

        // Overwrite policy: six captures into four slots keep captures 3..6
        b2.arm = 1;
        tick();
        b2.arm = 0;
        for (int i = 0; i < 6; i++) begin
            b2.instruction = 32'h300 + i; b2.stop = (i == 5);
            tick();
        end
        b2.stop = 0;
        check("t3_overflow",  b2.overflow,  64'd1);
        check("t3_count",     b2.count,     64'd4);
        check("t3_capturing", b2.capturing, 64'd0);
        b2.rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_pop_instr", b2.rd_instruction, 64'(32'h302 + i));
        end
        b2.rd_en = 0;

        // Full buffer with push and pop every cycle: no overflow, order kept
        b2.arm = 1;
        tick();
        b2.arm = 0;
        check("t4_rearm_overflow", b2.overflow, 64'd0);
        for (int i = 0; i < 4; i++) begin
            b2.instruction = 32'h400 + i;
            tick();
        end
        check("t4_fill_count", b2.count, 64'd4);
        check("t4_fill_full",  b2.full,  64'd1);
        b2.rd_en = 1;
        for (int i = 0; i < 5; i++) begin
            b2.instruction = 32'h404 + i; b2.stop = (i == 4);
            tick();
            check("t4_pp_instr",    b2.rd_instruction, 64'(32'h400 + i));
            check("t4_pp_count",    b2.count,          64'd4);
            check("t4_pp_overflow", b2.overflow,       64'd0);
        end
        b2.stop = 0;
        check("t4_capturing", b2.capturing, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_drain_instr", b2.rd_instruction, 64'(32'h405 + i));
        end
        b2.rd_en = 0;

        // Watchdog: constant instruction gives one entry then times out 8 cycles later
        b3.instruction = 32'h500; b3.result = 32'h55; b3.arm = 1;
        tick();
        b3.arm = 0;
        tick();
        check("t5_count1", b3.count, 64'd1);
        repeat (7) tick();
        check("t5_still_capturing", b3.capturing, 64'd1);
        check("t5_no_timeout_yet",  b3.timeout,   64'd0);
        tick();
        check("t5_done",    b3.capturing, 64'd0);
        check("t5_timeout", b3.timeout,   64'd1);
        check("t5_count",   b3.count,     64'd1);
        b3.arm = 1;
        tick();
        b3.arm = 0;
        check("t5_rearm_timeout",   b3.timeout,   64'd0);
        check("t5_rearm_capturing", b3.capturing, 64'd1);
        tick();
        check("t5_rearm_count", b3.count, 64'd2);
        b3.clear = 1;
        tick();
        b3.clear = 0;
        check("t5_clear_count",     b3.count,     64'd0);
        check("t5_clear_empty",     b3.empty,     64'd1);
        check("t5_clear_capturing", b3.capturing, 64'd1);
        b3.stop = 1;
        tick();
        b3.stop = 0;

        // Reset asserted between edges while capturing with three entries
        b0.arm = 1;
        tick();
        b0.arm = 0;
        for (int i = 0; i < 3; i++) begin
            b0.instruction = 32'h600 + i;
            tick();
        end
        check("t6_count3",    b0.count,     64'd3);
        check("t6_capturing", b0.capturing, 64'd1);
        #2;
        reset = 1'b1;
        ncyc  = 0;
        #1;
        check("t6_rst_empty",     b0.empty,       64'd1);
        check("t6_rst_count",     b0.count,       64'd0);
        check("t6_rst_cycle",     b0.cycle_count, 64'd0);
        check("t6_rst_capturing", b0.capturing,   64'd0);
        tick();
        reset = 1'b0;
        b0.rd_en = 1;
        tick();
        check("t6_read_after_rst", b0.rd_valid, 64'd0);
        b0.rd_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
